// File: rtl/mem_arbiter_pkg.sv
// mem_arbiter_pkg: FSM state type and default widths shared by the arbiter files
package mem_arbiter_pkg;
   localparam int ADDR_W_DEF = 16;
   localparam int DATA_W_DEF = 64;
   typedef enum logic [1:0] {IDLE, ACCESS, WAIT, RESP} state_t;
endpackage

// File: rtl/mem_arb_sel.sv
// mem_arb_sel: winner select, round-robin with MEM_ARBITER_RR_EN defined, else fixed priority to port 0
module mem_arb_sel
   import mem_arbiter_pkg::*;
(
   input  logic clk,
   input  logic rst_n,
   input  logic req0,
   input  logic req1,
   input  logic upd,
   input  logic upd_port,
   output logic sel
);
`ifdef MEM_ARBITER_RR_EN
   logic ptr;
   always_ff @(posedge clk)
      if (!rst_n) ptr <= 1'b0;
      else if (upd) ptr <= ~upd_port;
   always_comb sel = (req0 && req1) ? ptr : req1;
`else
   logic unused;
   always_comb unused = &{1'b0, clk, rst_n, upd, upd_port};
   always_comb sel = req1 && !req0;
`endif
endmodule

// File: rtl/mem_arbiter.sv
// mem_arbiter: two-port single-transaction memory arbiter; MEM_ARBITER_RR_EN selects round-robin
module mem_arbiter
   import mem_arbiter_pkg::*;
#(
   parameter int ADDR_W = ADDR_W_DEF,
   parameter int DATA_W = DATA_W_DEF,
   parameter int RD_LAT = 1
) (
   input  logic              clk,
   input  logic              rst_n,
   input  logic              req0,
   input  logic              req1,
   input  logic              we0,
   input  logic              we1,
   input  logic [ADDR_W-1:0] addr0,
   input  logic [ADDR_W-1:0] addr1,
   input  logic [DATA_W-1:0] wdata0,
   input  logic [DATA_W-1:0] wdata1,
   output logic              gnt0,
   output logic              gnt1,
   output logic              rvalid0,
   output logic              rvalid1,
   output logic [DATA_W-1:0] rdata0,
   output logic [DATA_W-1:0] rdata1,
   output logic [ADDR_W-1:0] mem_addr,
   output logic [DATA_W-1:0] mem_wdata,
   output logic              mem_we,
   input  logic [DATA_W-1:0] mem_rdata
);
   localparam logic [1:0] WAIT_LAST = 2'(RD_LAT - 1);
   state_t     state, state_nx;
   logic       win, lat_we, sel;
   logic [1:0] cnt;
   mem_arb_sel u_sel (
      .clk      (clk),
      .rst_n    (rst_n),
      .req0     (req0),
      .req1     (req1),
      .upd      (state == ACCESS),
      .upd_port (win),
      .sel      (sel)
   );
   always_comb begin
      state_nx = (state == IDLE)   ? ((req0 || req1) ? ACCESS : IDLE)
               : (state == ACCESS) ? (lat_we ? IDLE : (RD_LAT == 1 ? RESP : WAIT))
               : (state == WAIT)   ? ((cnt == WAIT_LAST) ? RESP : WAIT)
               : IDLE;
      gnt0   = (state == ACCESS) && !win;
      gnt1   = (state == ACCESS) && win;
      mem_we = (state == ACCESS) && lat_we;
   end
   // mem_addr/mem_wdata double as the latched request, so they hold outside ACCESS
   always_ff @(posedge clk) begin
      if (!rst_n) begin
         state     <= IDLE;
         cnt       <= 2'd1;
         win       <= 1'b0;
         lat_we    <= 1'b0;
         mem_addr  <= '0;
         mem_wdata <= '0;
         rvalid0   <= 1'b0;
         rvalid1   <= 1'b0;
         rdata0    <= '0;
         rdata1    <= '0;
      end else begin
         state   <= state_nx;
         cnt     <= (state == WAIT) ? cnt + 2'd1 : 2'd1;
         rvalid0 <= (state == RESP) && !win;
         rvalid1 <= (state == RESP) && win;
         if (state == IDLE && (req0 || req1)) begin
            win       <= sel;
            lat_we    <= sel ? we1 : we0;
            mem_addr  <= sel ? addr1 : addr0;
            mem_wdata <= sel ? wdata1 : wdata0;
         end
         if (state == RESP && !win) rdata0 <= mem_rdata;
         if (state == RESP && win) rdata1 <= mem_rdata;
      end
   end
endmodule

// File: tb/tb_mem_arbiter.sv
// tb_mem_arbiter: randomized and directed checks of mem_arbiter against a transaction-level model
module tb_mem_arbiter;
   localparam int RD_LAT = 3;
`ifdef MEM_ARBITER_RR_EN
   localparam int RR = 1;
`else
   localparam int RR = 0;
`endif
   logic        clk = 1'b0;
   logic        rst_n;
   logic [1:0]  req, we;
   logic [15:0] addr_v [2];
   logic [63:0] wdata_v [2];
   logic        gnt0, gnt1, rvalid0, rvalid1, mem_we;
   logic [63:0] rdata0, rdata1, mem_wdata, mem_rdata;
   logic [15:0] mem_addr;
   logic [63:0] mem_arr [65536];
   logic [63:0] ref_mem [65536];
   logic [63:0] pipe [RD_LAT];
   logic [1:0]  req_seen = 2'b00, gnt_q = 2'b00;
   int          cyc = 0;
   int          n_chk = 0, n_fail = 0;
   logic        exp_v = 1'b0;
   int          exp_p, exp_cyc, last_win;
   logic [63:0] exp_d, last_wd, hold0, hold1;
   logic [15:0] last_addr;
   logic [63:0] rv0_log [$];

   mem_arbiter #(.ADDR_W(16), .DATA_W(64), .RD_LAT(RD_LAT)) dut (
      .clk(clk), .rst_n(rst_n),
      .req0(req[0]), .req1(req[1]), .we0(we[0]), .we1(we[1]),
      .addr0(addr_v[0]), .addr1(addr_v[1]), .wdata0(wdata_v[0]), .wdata1(wdata_v[1]),
      .gnt0(gnt0), .gnt1(gnt1), .rvalid0(rvalid0), .rvalid1(rvalid1),
      .rdata0(rdata0), .rdata1(rdata1),
      .mem_addr(mem_addr), .mem_wdata(mem_wdata), .mem_we(mem_we), .mem_rdata(mem_rdata)
   );

   always #5 clk = ~clk;
   assign mem_rdata = pipe[RD_LAT-1];
   always @(posedge clk) begin
      cyc      <= cyc + 1;
      req_seen <= req;
      gnt_q    <= {gnt1, gnt0};
   end

   function automatic logic [63:0] init_val(input logic [15:0] a);
      return {16'hC0DE, a, ~a, a ^ 16'h5A5A};
   endfunction

   task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
      n_chk++;
      if (got !== exp) begin
         n_fail++;
         $display("FAIL %s: got %0h, expected %0h", tag, got, exp);
      end
   endtask

   // Transaction-level model: one outstanding transaction, grant rules, hold rules
   task automatic mon();
      int p, ew;
      logic rv;
      if (!rst_n) begin
         exp_v = 1'b0; last_win = 1; last_addr = '0; last_wd = '0; hold0 = '0; hold1 = '0;
         return;
      end
      chk("gnt_excl", 64'(gnt0 & gnt1), 64'd0);
      chk("rv_excl", 64'(rvalid0 & rvalid1), 64'd0);
      if (gnt0 | gnt1) begin
         p  = int'(gnt1);
         ew = (req_seen == 2'b11) ? (RR != 0 ? 1 - last_win : 0) : int'(req_seen[1]);
         chk("gnt_req", 64'(req_seen[p]), 64'd1);
         chk("winner", 64'(p), 64'(ew));
         chk("gnt_addr", 64'(mem_addr), 64'(addr_v[p]));
         chk("gnt_wdata", mem_wdata, wdata_v[p]);
         chk("gnt_we", 64'(mem_we), 64'(we[p]));
         if (we[p]) ref_mem[addr_v[p]] = wdata_v[p];
         else begin
            exp_v = 1'b1; exp_p = p; exp_cyc = cyc + RD_LAT + 1; exp_d = ref_mem[addr_v[p]];
         end
         last_win = p; last_addr = addr_v[p]; last_wd = wdata_v[p];
      end else begin
         chk("idle_we", 64'(mem_we), 64'd0);
         chk("hold_addr", 64'(mem_addr), 64'(last_addr));
         chk("hold_wdata", mem_wdata, last_wd);
      end
      rv = exp_v && exp_cyc == cyc;
      chk("rvalid0", 64'(rvalid0), 64'(rv && exp_p == 0));
      chk("rvalid1", 64'(rvalid1), 64'(rv && exp_p == 1));
      if (rvalid0) rv0_log.push_back(rdata0);
      if (rv) begin
         if (exp_p == 0) hold0 = exp_d; else hold1 = exp_d;
         exp_v = 1'b0;
      end
      chk("rdata0", rdata0, hold0);
      chk("rdata1", rdata1, hold1);
   endtask

   task automatic do_reset();
      rst_n = 1'b0; req = 2'b00;
      repeat (2) @(posedge clk);
      #1 rst_n = 1'b1;
   endtask

   task automatic do_req(input int p, input logic w, input logic [15:0] a, input logic [63:0] d,
                         output int lat);
      @(posedge clk); #1;
      we[p] = w; addr_v[p] = a; wdata_v[p] = d; req[p] = 1'b1;
      lat = 0;
      do begin @(negedge clk); lat++; end while (!(p == 1 ? gnt1 : gnt0) && lat < 100);
      @(posedge clk); #1 req[p] = 1'b0;
   endtask

   task automatic wait_rv(input int p, output int n, output logic [63:0] d);
      n = 0;
      do begin @(negedge clk); n++; end while (!(p == 1 ? rvalid1 : rvalid0) && n < 20);
      d = (p == 1) ? rdata1 : rdata0;
   endtask

   initial begin
      #5_000_000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1, "watchdog");
   end

   initial begin
      int lat, n, cnt, base, done;
      logic [63:0] d;
      int gq [$];
      rst_n = 1'b0; req = 2'b00; we = 2'b00;
      addr_v[0] = '0; addr_v[1] = '0; wdata_v[0] = '0; wdata_v[1] = '0;
      for (int i = 0; i < 65536; i++) begin
         mem_arr[i] = init_val(16'(i));
         ref_mem[i] = mem_arr[i];
      end
      mem_arr[4] = 64'hDEAD_BEEF;
      ref_mem[4] = 64'hDEAD_BEEF;
      fork
         forever begin
            @(posedge clk);
            if (mem_we === 1'b1) mem_arr[mem_addr] <= mem_wdata;
            pipe[0] <= mem_arr[mem_addr];
            for (int i = 1; i < RD_LAT; i++) pipe[i] <= pipe[i-1];
         end
         forever begin
            @(negedge clk);
            mon();
         end
      join_none

      do_reset();
      @(negedge clk);
      chk("rst_ctl", 64'({gnt0, gnt1, rvalid0, rvalid1, mem_we}), 64'd0);
      chk("rst_rdata", rdata0 | rdata1, 64'd0);
      chk("rst_addr", 64'(mem_addr), 64'd0);
      chk("rst_wdata", mem_wdata, 64'd0);

      do_req(0, 1'b0, 16'h0004, 64'd0, lat);
      chk("rd_gnt_lat", 64'(lat), 64'd2);
      wait_rv(0, n, d);
      chk("rd_rv_lat", 64'(n), 64'(RD_LAT + 1));
      chk("rd_data", d, 64'hDEAD_BEEF);

      do_req(1, 1'b1, 16'h0000, 64'h00FF, lat);
      chk("wr_gnt_lat", 64'(lat), 64'd2);
      cnt = 0;
      repeat (6) begin @(negedge clk); if (rvalid1) cnt++; end
      chk("wr_no_rv", 64'(cnt), 64'd0);
      do_req(0, 1'b0, 16'h0000, 64'd0, lat);
      wait_rv(0, n, d);
      chk("wr_readback", d, 64'h00FF);

      do_reset();
      @(posedge clk); #1;
      we = 2'b11; addr_v[0] = 16'h0010; addr_v[1] = 16'h0011;
      wdata_v[0] = 64'h1111; wdata_v[1] = 64'h2222; req = 2'b11;
      n = 0;
      while (gq.size() < 4 && n < 100) begin
         @(negedge clk); n++;
         if (gnt0 | gnt1) gq.push_back(int'(gnt1));
      end
      @(posedge clk); #1 req = 2'b00;
      chk("tie_cnt", 64'(gq.size()), 64'd4);
      foreach (gq[i]) chk("tie_winner", 64'(gq[i]), 64'(RR != 0 ? i % 2 : 0));

      do_req(0, 1'b0, 16'h0020, 64'd0, lat);
      we[1] = 1'b0; addr_v[1] = 16'h0021; req[1] = 1'b1;
      @(posedge clk); #1 req[1] = 1'b0;
      cnt = 0;
      repeat (10) begin @(negedge clk); if (gnt1) cnt++; end
      chk("withdraw_no_gnt1", 64'(cnt), 64'd0);

      base = rv0_log.size();
      do_req(0, 1'b0, 16'h05FF, 64'd0, lat);
      do_req(0, 1'b0, 16'h0100, 64'd0, lat);
      wait_rv(0, n, d);
      chk("b2b_cnt", 64'(rv0_log.size() - base), 64'd2);
      if (rv0_log.size() >= base + 2) begin
         chk("b2b_first", rv0_log[base], init_val(16'h05FF));
         chk("b2b_second", rv0_log[base+1], init_val(16'h0100));
      end

      do_req(0, 1'b0, 16'h0007, 64'd0, lat);
      rst_n = 1'b0;
      @(posedge clk); #1 rst_n = 1'b1;
      @(negedge clk);
      chk("rstw_ctl", 64'({gnt0, gnt1, rvalid0, rvalid1, mem_we}), 64'd0);
      chk("rstw_rdata", rdata0 | rdata1, 64'd0);
      chk("rstw_addr", 64'(mem_addr), 64'd0);
      chk("rstw_wdata", mem_wdata, 64'd0);
      cnt = 0;
      repeat (8) begin @(negedge clk); if (rvalid0 | rvalid1) cnt++; end
      chk("rstw_no_rv", 64'(cnt), 64'd0);
      do_req(1, 1'b0, 16'h0008, 64'd0, lat);
      chk("rstw_idle_lat", 64'(lat), 64'd2);
      wait_rv(1, n, d);
      chk("rstw_rd", d, init_val(16'h0008));

      done = 0;
      for (int c = 0; c < 4000 && done < 60; c++) begin
         @(posedge clk); #1;
         for (int p = 0; p < 2; p++) begin
            if (req[p] && gnt_q[p]) begin
               req[p] = 1'b0;
               done++;
            end else if (!req[p] && $urandom_range(0, 3) == 0) begin
               we[p]      = 1'($urandom_range(0, 1));
               addr_v[p]  = 16'($urandom_range(0, 15));
               wdata_v[p] = {$urandom, $urandom};
               req[p]     = 1'b1;
            end
         end
      end
      req = 2'b00;
      chk("rand_done", 64'(done >= 60), 64'd1);
      repeat (RD_LAT + 6) @(negedge clk);
      chk("rand_drain", 64'(exp_v), 64'd0);

      $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
      $finish;
   end
endmodule

// File: doc/mem_arbiter.md
MEM_ARBITER -- requirements
Module: mem_arbiter

Interface
REQ-001 SHALL have parameter ADDR_W, default 16, memory word-address width.
REQ-002 SHALL have parameter DATA_W, default 64, memory data width.
REQ-003 SHALL have parameter RD_LAT, default 1, memory read latency in cycles (range 1..4).
REQ-004 SHALL have port clk  in  1  single clock; all logic on rising edge.
REQ-005 SHALL have port rst_n  in  1  reset; synchronous, active-low.
REQ-006 SHALL have ports req0/req1  in  1  access request, port 0 (core) / port 1 (loader).
REQ-007 SHALL have ports we0/we1  in  1  write (1) / read (0) qualifier for each request.
REQ-008 SHALL have ports addr0/addr1  in  ADDR_W  request address.
REQ-009 SHALL have ports wdata0/wdata1  in  DATA_W  write data.
REQ-010 SHALL have ports gnt0/gnt1  out  1  one-cycle grant pulse.
REQ-011 SHALL have ports rvalid0/rvalid1  out  1  one-cycle read-data-valid pulse.
REQ-012 SHALL have ports rdata0/rdata1  out  DATA_W  read data, meaningful only while rvalid is high.
REQ-013 SHALL have port mem_addr  out  ADDR_W  address to the memory.
REQ-014 SHALL have port mem_wdata  out  DATA_W  write data to the memory.
REQ-015 SHALL have port mem_we  out  1  memory write enable.
REQ-016 SHALL have port mem_rdata  in  DATA_W  memory read data, valid RD_LAT cycles after the address is presented.

Function
REQ-017 SHALL use a state machine with states IDLE, ACCESS, WAIT and RESP, and SHALL complete one transaction at a time.
REQ-018 In IDLE with any req high, SHALL select a winner, latch its we/addr/wdata and move to ACCESS on the next edge.
REQ-019 In ACCESS, SHALL drive mem_addr/mem_wdata from the latched values, assert the winner's gnt for exactly one cycle, and assert mem_we only if the request is a write.
REQ-020 After a write ACCESS, SHALL return to IDLE; a write is complete at gnt and SHALL NOT produce rvalid.
REQ-021 After a read ACCESS, SHALL wait in WAIT, counting RD_LAT-1 cycles (zero cycles when RD_LAT=1), then enter RESP.
REQ-022 In RESP, SHALL pulse the winner's rvalid for one cycle with rdata = mem_rdata, then return to IDLE.
- The first rvalid for a read appears RD_LAT+1 cycles after gnt.
REQ-023 Requesters SHALL hold req, we, addr and wdata stable until gnt; the arbiter SHALL sample these inputs only in IDLE.
REQ-024 Outside ACCESS, SHALL hold mem_we at 0 and mem_addr/mem_wdata at their last values.
REQ-025 gnt0 and gnt1 SHALL never be high together; rvalid0 and rvalid1 SHALL never be high together.
REQ-026 A request deasserted before gnt SHALL be treated as withdrawn without error.
REQ-027 The non-selected port's rdata SHALL hold its previous value.

Reset
REQ-028 With rst_n low at a clock edge, SHALL force state IDLE, all gnt/rvalid/mem_we to 0, rdata/mem_addr/mem_wdata to 0, and the priority pointer to port 0.
REQ-029 Reset during ACCESS, WAIT or RESP SHALL abort the transaction with no further gnt or rvalid for it; a write already granted is not undone.

Configuration
REQ-030 With MEM_ARBITER_RR_EN defined, SHALL use round-robin arbitration.
- When both ports request in IDLE, the port not granted last wins.
- The pointer updates on each grant.
REQ-031 With MEM_ARBITER_RR_EN undefined, SHALL use fixed priority: port 0 always wins a tie, and no pointer register exists.

Structure
REQ-032 SHALL place the state enum (IDLE/ACCESS/WAIT/RESP) and the ADDR_W/DATA_W defaults in package mem_arbiter_pkg.
REQ-033 SHALL implement winner selection (fixed or round-robin) in a single sub-module, mem_arb_sel; the FSM and datapath stay in mem_arbiter.

Verification
REQ-034 The bench SHALL cover these scenarios:
- Single read: req0=1, we0=0, addr0=16'h0004, memory preloaded 64'hDEAD_BEEF -> gnt0 at cycle 2, rvalid0 at cycle 2+RD_LAT+1, rdata0=64'hDEAD_BEEF.
- Single write: req1=1, we1=1, addr1=16'h0000, wdata1=64'h00FF -> gnt1 with mem_we=1 for one cycle, no rvalid1; a subsequent read of 16'h0000 returns 64'h00FF.
- Tie under fixed priority: req0 and req1 both held high -> every grant goes to port 0 while req0 stays asserted.
- Tie with MEM_ARBITER_RR_EN: both held high for four transactions -> grants alternate 0,1,0,1.
- Reset in WAIT with RD_LAT=3: rst_n low for one cycle -> no rvalid, state IDLE, all outputs 0.
- Back-to-back reads at addr 16'h05FF then 16'h0100 on port 0 -> two rvalid0 pulses, in order, each with the correct data.
